// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of the RAM stream reader.
// master = reader side, slave = the environment (command source, RAM, stream sink).
interface ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_do;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, base_addr, length, ram_do, m_ready,
    output busy, done, ram_addr, m_data, m_valid, m_last
  );
  modport slave (
    output start, base_addr, length, ram_do, m_ready,
    input  busy, done, ram_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Wrapping burst reader for a 1-cycle-latency block RAM, streaming the words out
// through a small credit-protected FIFO with a last-beat marker.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_stream_reader_if.master bus_if
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int STAGES = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic [STAGES:1]       vld_pipe_q, last_pipe_q;
  logic                  issue, issue_last;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic [PW+1:0]         occ;
  logic                  push, pop, credit;

  // Stage 2 marks the cycle in which ram_do holds a word we asked for.
  assign push   = vld_pipe_q[2];
  assign pop    = bus_if.m_valid & bus_if.m_ready;
  assign occ    = (PW+2)'(count_q) + (PW+2)'(vld_pipe_q[1]) + (PW+2)'(vld_pipe_q[2]);
  assign credit = occ < (PW+2)'(FIFO_DEPTH);

  // The start-accept edge doubles as the first issue, giving 2-cycle latency.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    ram_addr_d = ram_addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: if (bus_if.start) begin
        if (bus_if.length == '0) begin
          done_d = 1'b1;
        end else begin
          issue      = 1'b1;
          issue_last = (bus_if.length == (ADDR_WIDTH+1)'(1));
          ram_addr_d = bus_if.base_addr;
          addr_cnt_d = bus_if.base_addr + 1'b1;
          rem_d      = bus_if.length - 1'b1;
          state_d    = issue_last ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: if (credit) begin
        issue      = 1'b1;
        issue_last = (rem_q == (ADDR_WIDTH+1)'(1));
        ram_addr_d = addr_cnt_q;
        addr_cnt_d = addr_cnt_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && bus_if.m_last) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_cnt_q  <= '0;
      ram_addr_q  <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      ram_addr_q  <= ram_addr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      vld_pipe_q  <= {vld_pipe_q[1], issue};
      last_pipe_q <= {last_pipe_q[1], issue_last};
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= bus_if.ram_do;
      fifo_last[wr_ptr_q] <= last_pipe_q[2];
    end
  end

  // Data is gated by valid so the stream outputs read zero when idle or in reset.
  assign bus_if.m_valid  = (count_q != '0);
  assign bus_if.m_data   = bus_if.m_valid ? fifo_data[rd_ptr_q] : '0;
  assign bus_if.m_last   = bus_if.m_valid & fifo_last[rd_ptr_q];
  assign bus_if.busy     = (state_q != S_IDLE);
  assign bus_if.done     = done_q;
  assign bus_if.ram_addr = ram_addr_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a queue-based model predicts every beat,
// busy and done each cycle; literal checks pin latency, wrap and edge lengths.
module tb_ram_stream_reader;
  typedef struct { logic [15:0] d; logic l; } beat_t;

  logic clk, rst_n;
  ram_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  ram_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus)
  );

  logic [15:0] mem [256];
  beat_t       mq[$];
  logic [15:0] got[$];
  int          n_tests = 0, n_fail = 0;
  logic        mdl_busy = 0, mdl_done = 0, was_busy;
  logic        stall_prev = 0, stall_l;
  logic [15:0] stall_d;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial for (int i = 0; i < 256; i++) begin
    logic [7:0] a;
    a = i[7:0];
    mem[i] = {~a, a};
  end

  always @(posedge clk) bus.ram_do <= mem[bus.ram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: what each accepted start must produce, checked every negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.m_valid, 0);
      mq.delete();
      mdl_busy = 0; mdl_done = 0; stall_prev = 0;
    end else begin
      chk("busy", bus.busy, mdl_busy);
      chk("done", bus.done, mdl_done);
      chk("busy_done_excl", bus.busy & bus.done, 0);
      if (bus.m_valid) begin
        chk("beat_expected", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          chk("m_data", bus.m_data, mq[0].d);
          chk("m_last", bus.m_last, mq[0].l);
        end
        if (stall_prev) begin
          chk("stall_data", bus.m_data, stall_d);
          chk("stall_last", bus.m_last, stall_l);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_d = bus.m_data;
      stall_l = bus.m_last;
      was_busy = mdl_busy;
      mdl_done = 0;
      if (bus.m_valid && bus.m_ready && mq.size() != 0) begin
        got.push_back(bus.m_data);
        if (mq[0].l) begin mdl_done = 1; mdl_busy = 0; end
        void'(mq.pop_front());
      end
      if (bus.start && !was_busy) begin
        if (bus.length == 0) mdl_done = 1;
        else begin
          mdl_busy = 1;
          for (int i = 0; i < int'(bus.length); i++)
            mq.push_back('{mem[(int'(bus.base_addr) + i) % 256], i == int'(bus.length) - 1});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [8:0] l, input bit clr);
    if (clr) got.delete();
    bus.base_addr = b; bus.length = l; bus.start = 1;
    tick;
    bus.start = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.busy && !bus.done && mq.size() == 0) begin ok = 1; break; end
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      tick;
    end
    chk("idle_timeout", ok, 1);
    bus.m_ready = 1;
    tick;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_valid"}, bus.m_valid, 0);
    chk({nm, "_last"}, bus.m_last, 0);
    chk({nm, "_data"}, bus.m_data, 0);
    chk({nm, "_addr"}, bus.ram_addr, 0);
  endtask

  initial begin
    bit ok;
    rst_n = 0;
    bus.start = 0; bus.base_addr = '0; bus.length = '0; bus.m_ready = 0;
    tick; tick;
    chk_zero("reset");
    rst_n = 1;
    tick; tick;
    chk_zero("post_reset");

    // Basic burst with first-beat latency
    bus.m_ready = 1;
    pulse_start(8'h10, 9'd4, 1);
    chk("basic_addr0", bus.ram_addr, 8'h10);
    chk("basic_lat0", bus.m_valid, 0);
    tick;
    chk("basic_lat1", bus.m_valid, 0);
    tick;
    chk("basic_lat2", bus.m_valid, 1);
    chk("basic_first", bus.m_data, 16'hEF10);
    wait_idle(0);
    chk("basic_count", got.size(), 4);
    chk("basic_beat3", got[3], 16'hEC13);

    // Address wrap
    pulse_start(8'hFE, 9'd4, 1);
    chk("wrap_a0", bus.ram_addr, 8'hFE);
    tick;
    chk("wrap_a1", bus.ram_addr, 8'hFF);
    tick;
    chk("wrap_a2", bus.ram_addr, 8'h00);
    tick;
    chk("wrap_a3", bus.ram_addr, 8'h01);
    wait_idle(0);
    chk("wrap_count", got.size(), 4);
    chk("wrap_beat2", got[2], 16'hFF00);

    // Random backpressure
    bus.m_ready = 0;
    pulse_start(8'h30, 9'd16, 1);
    wait_idle(1);
    chk("bp_count", got.size(), 16);
    chk("bp_beat15", got[15], 16'hC03F);

    // Zero length
    pulse_start(8'h00, 9'd0, 1);
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    tick;
    chk("len0_done_off", bus.done, 0);
    chk("len0_valid", bus.m_valid, 0);

    // Full-RAM burst
    pulse_start(8'h80, 9'd256, 1);
    wait_idle(0);
    chk("full_count", got.size(), 256);
    chk("full_first", got[0], 16'h7F80);
    chk("full_last", got[255], 16'h807F);

    // Start while busy is ignored
    pulse_start(8'h00, 9'd8, 1);
    tick;
    pulse_start(8'h40, 9'd2, 0);
    wait_idle(0);
    chk("busy_start_count", got.size(), 8);
    chk("busy_start_beat7", got[7], 16'hF807);

    // Reset mid-burst, then a fresh burst
    pulse_start(8'h20, 9'd8, 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (got.size() >= 3) begin ok = 1; break; end
      tick;
    end
    chk("mid_timeout", ok, 1);
    #2 rst_n = 0;
    #1 chk_zero("mid_reset");
    tick;
    rst_n = 1;
    tick; tick; tick;
    chk("mid_beats", got.size(), 3);
    pulse_start(8'h50, 9'd3, 1);
    wait_idle(0);
    chk("fresh_count", got.size(), 3);
    chk("fresh_beat2", got[2], 16'hAD52);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
